// File: rtl/regfile_sb_bypass_if.sv
// Register file bus: two read ports, two write ports, load scoreboard set and status.
// The master drives addresses, write data and scoreboard sets; the slave is the register file.
interface regfile_sb_bypass_if #(
   parameter int DW = 32,
   parameter int AW = 5
);
   localparam int N = 1 << AW;

   logic [AW-1:0] rd_addr_a;
   logic [DW-1:0] rd_data_a;
   logic          busy_a;
   logic [AW-1:0] rd_addr_b;
   logic [DW-1:0] rd_data_b;
   logic          busy_b;
   logic          wr0_en;
   logic [AW-1:0] wr0_addr;
   logic [DW-1:0] wr0_data;
   logic          wr1_en;
   logic [AW-1:0] wr1_addr;
   logic [DW-1:0] wr1_data;
   logic          sb_set;
   logic [AW-1:0] sb_addr;
   logic [N-1:0]  busy_vec;
   logic          conflict;

   modport master (
      output rd_addr_a, rd_addr_b,
      output wr0_en, wr0_addr, wr0_data,
      output wr1_en, wr1_addr, wr1_data,
      output sb_set, sb_addr,
      input  rd_data_a, busy_a, rd_data_b, busy_b, busy_vec, conflict
   );

   modport slave (
      input  rd_addr_a, rd_addr_b,
      input  wr0_en, wr0_addr, wr0_data,
      input  wr1_en, wr1_addr, wr1_data,
      input  sb_set, sb_addr,
      output rd_data_a, busy_a, rd_data_b, busy_b, busy_vec, conflict
   );
endinterface

// File: rtl/regfile_sb_bypass.sv
// Dual-write-port register file with optional write-to-read bypass and a per-register
// load scoreboard; port 1 (load writeback) is the younger writer and wins collisions.
module regfile_sb_bypass #(
   parameter int          DW      = 32,
   parameter int          AW      = 5,
   parameter bit          BYPASS  = 1'b1,
   parameter int          SP_IDX  = 29,
   parameter logic [DW-1:0] SP_INIT = 32'h0000_0400,
   parameter int          RA_IDX  = 31,
   parameter logic [DW-1:0] RA_INIT = 32'h0040_000c
) (
   input logic               clk,
   input logic               reset,
   regfile_sb_bypass_if.slave bus
);
   localparam int N = 1 << AW;

   logic [DW-1:0] regs_q [N];
   logic [DW-1:0] regs_d [N];
   logic [N-1:0]  busy_q, busy_d;
   logic          conflict_q, conflict_d;

   logic wr0_ok, wr1_ok, sb_ok;

   assign wr0_ok = bus.wr0_en && (bus.wr0_addr != '0);
   assign wr1_ok = bus.wr1_en && (bus.wr1_addr != '0);
   assign sb_ok  = bus.sb_set && (bus.sb_addr != '0);

   // Port 1 applied last so the load overrides an ALU write to the same register.
   always_comb begin
      regs_d = regs_q;
      if (wr0_ok) regs_d[bus.wr0_addr] = bus.wr0_data;
      if (wr1_ok) regs_d[bus.wr1_addr] = bus.wr1_data;
      regs_d[0] = '0;
   end

   // Clear before set so a new load to the same register keeps it busy.
   always_comb begin
      busy_d = busy_q;
      if (bus.wr1_en) busy_d[bus.wr1_addr] = 1'b0;
      if (sb_ok)      busy_d[bus.sb_addr]  = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_comb begin
      conflict_d = conflict_q;
      if (sb_ok && busy_q[bus.sb_addr] && !(bus.wr1_en && (bus.wr1_addr == bus.sb_addr)))
         conflict_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) begin
            if (i == SP_IDX)      regs_q[i] <= SP_INIT;
            else if (i == RA_IDX) regs_q[i] <= RA_INIT;
            else                  regs_q[i] <= '0;
         end
         busy_q     <= '0;
         conflict_q <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         busy_q     <= busy_d;
         conflict_q <= conflict_d;
      end
   end

   function automatic logic [DW-1:0] read_mux(input logic [AW-1:0] addr,
                                              input logic [DW-1:0] stored);
      logic [DW-1:0] val;
      val = stored;
      if (addr == '0)
         val = '0;
      else if (BYPASS && wr1_ok && (bus.wr1_addr == addr))
         val = bus.wr1_data;
      else if (BYPASS && wr0_ok && (bus.wr0_addr == addr))
         val = bus.wr0_data;
      return val;
   endfunction

   // A register whose load data is being bypassed this cycle is no longer a hazard.
   function automatic logic busy_mux(input logic [AW-1:0] addr);
      return busy_q[addr] && !(BYPASS && bus.wr1_en && (bus.wr1_addr == addr));
   endfunction

   assign bus.rd_data_a = read_mux(bus.rd_addr_a, regs_q[bus.rd_addr_a]);
   assign bus.rd_data_b = read_mux(bus.rd_addr_b, regs_q[bus.rd_addr_b]);
   assign bus.busy_a    = busy_mux(bus.rd_addr_a);
   assign bus.busy_b    = busy_mux(bus.rd_addr_b);
   assign bus.busy_vec  = busy_q;
   assign bus.conflict  = conflict_q;
endmodule

// File: tb/tb_regfile_sb_bypass.sv
// Bench for regfile_sb_bypass: one bypassing and one non-bypassing instance share stimulus;
// expected values are queued by the stimulus and compared by a separate monitor.
module tb_regfile_sb_bypass;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   regfile_sb_bypass_if #(.DW(32), .AW(5)) bp ();
   regfile_sb_bypass_if #(.DW(32), .AW(5)) bn ();

   regfile_sb_bypass #(.BYPASS(1'b1)) dut_byp (.clk(clk), .reset(reset), .bus(bp.slave));
   regfile_sb_bypass #(.BYPASS(1'b0)) dut_nob (.clk(clk), .reset(reset), .bus(bn.slave));

   logic [4:0]  rd_a, rd_b, wa0, wa1, sba;
   logic [31:0] wd0, wd1;
   logic        we0, we1, sbs;

   assign bp.rd_addr_a = rd_a;  assign bn.rd_addr_a = rd_a;
   assign bp.rd_addr_b = rd_b;  assign bn.rd_addr_b = rd_b;
   assign bp.wr0_en    = we0;   assign bn.wr0_en    = we0;
   assign bp.wr0_addr  = wa0;   assign bn.wr0_addr  = wa0;
   assign bp.wr0_data  = wd0;   assign bn.wr0_data  = wd0;
   assign bp.wr1_en    = we1;   assign bn.wr1_en    = we1;
   assign bp.wr1_addr  = wa1;   assign bn.wr1_addr  = wa1;
   assign bp.wr1_data  = wd1;   assign bn.wr1_data  = wd1;
   assign bp.sb_set    = sbs;   assign bn.sb_set    = sbs;
   assign bp.sb_addr   = sba;   assign bn.sb_addr   = sba;

   localparam int S_RA = 0, S_RB = 1, S_BA = 2, S_BB = 3, S_BV = 4, S_CF = 5;
   localparam int D_BYP = 0, D_NOB = 1, D_BOTH = 2;

   typedef struct {
      int          dut;
      int          sel;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t q[$];
   int   n_pass = 0;
   int   n_total = 0;
   event check_now;

   task automatic push(input int dut, input int sel, input logic [31:0] v, input string name);
      exp_t e;
      e.sel = sel; e.exp = v; e.name = name;
      if (dut == D_BOTH) begin
         e.dut = D_BYP; q.push_back(e);
         e.dut = D_NOB; q.push_back(e);
      end else begin
         e.dut = dut; q.push_back(e);
      end
   endtask

   function automatic logic [31:0] actual(input int dut, input int sel);
      logic [31:0] v;
      v = '0;
      if (dut == D_BYP) begin
         case (sel)
            S_RA: v = bp.rd_data_a;
            S_RB: v = bp.rd_data_b;
            S_BA: v = {31'd0, bp.busy_a};
            S_BB: v = {31'd0, bp.busy_b};
            S_BV: v = bp.busy_vec;
            default: v = {31'd0, bp.conflict};
         endcase
      end else begin
         case (sel)
            S_RA: v = bn.rd_data_a;
            S_RB: v = bn.rd_data_b;
            S_BA: v = {31'd0, bn.busy_a};
            S_BB: v = {31'd0, bn.busy_b};
            S_BV: v = bn.busy_vec;
            default: v = {31'd0, bn.conflict};
         endcase
      end
      return v;
   endfunction

   initial begin
      forever begin
         @(negedge clk or check_now);
         while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e   = q.pop_front();
            act = actual(e.dut, e.sel);
            n_total++;
            if (act === e.exp) n_pass++;
            else $display("FAIL %s (dut%0d): got %h expected %h", e.name, e.dut, act, e.exp);
         end
      end
   end

   task automatic idle();
      we0 = 1'b0; wa0 = '0; wd0 = '0;
      we1 = 1'b0; wa1 = '0; wd1 = '0;
      sbs = 1'b0; sba = '0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      rd_a = '0; rd_b = '0;
      idle();

      // Reset state
      cyc();
      push(D_BOTH, S_BV, 32'h0, "busy_vec_in_reset");
      push(D_BOTH, S_CF, 32'h0, "conflict_in_reset");
      cyc();
      reset = 1'b1;
      rd_a = 5'd29; rd_b = 5'd31;
      push(D_BOTH, S_RA, 32'h0000_0400, "sp_init");
      push(D_BOTH, S_RB, 32'h0040_000c, "ra_init");
      push(D_BOTH, S_BV, 32'h0, "busy_vec_after_reset");
      push(D_BOTH, S_CF, 32'h0, "conflict_after_reset");
      cyc();
      rd_a = 5'd5;
      push(D_BOTH, S_RA, 32'h0, "reg5_zero");

      // Register 0 ignores writes, even through the bypass path
      cyc();
      we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hDEAD_BEEF; rd_a = 5'd0;
      push(D_BOTH, S_RA, 32'h0, "reg0_same_cycle");
      cyc();
      idle();
      push(D_BOTH, S_RA, 32'h0, "reg0_after_write");

      // Single write with bypass vs. one-cycle latency
      cyc();
      we0 = 1'b1; wa0 = 5'd8; wd0 = 32'h1234_5678; rd_a = 5'd8;
      push(D_BYP, S_RA, 32'h1234_5678, "wr0_bypass");
      push(D_NOB, S_RA, 32'h0, "wr0_no_bypass_old");
      cyc();
      idle();
      push(D_BOTH, S_RA, 32'h1234_5678, "wr0_next_cycle");

      // Dual-write collision: port 1 wins
      cyc();
      we0 = 1'b1; wa0 = 5'd10; wd0 = 32'hAAAA_0000;
      we1 = 1'b1; wa1 = 5'd10; wd1 = 32'h5555_FFFF; rd_a = 5'd10;
      push(D_BYP, S_RA, 32'h5555_FFFF, "collision_bypass");
      push(D_NOB, S_RA, 32'h0, "collision_no_bypass_old");
      cyc();
      idle();
      push(D_BOTH, S_RA, 32'h5555_FFFF, "collision_stored");

      // Load-use scoreboard
      cyc();
      sbs = 1'b1; sba = 5'd12; rd_b = 5'd12;
      push(D_BOTH, S_BV, 32'h0, "busy_not_yet");
      push(D_BOTH, S_BB, 32'h0, "busy_b_not_yet");
      cyc();
      idle();
      push(D_BOTH, S_BV, 32'h0000_1000, "busy12_set");
      push(D_BOTH, S_BB, 32'h1, "busy_b_12");
      cyc();
      we0 = 1'b1; wa0 = 5'd12; wd0 = 32'h0000_0055;
      push(D_BOTH, S_BB, 32'h1, "wr0_keeps_busy");
      push(D_BYP, S_RB, 32'h0000_0055, "wr0_bypass_b");
      push(D_NOB, S_RB, 32'h0, "wr0_no_bypass_b");
      cyc();
      idle();
      we1 = 1'b1; wa1 = 5'd12; wd1 = 32'h0000_0077;
      push(D_BOTH, S_BV, 32'h0000_1000, "busy12_after_wr0");
      push(D_BYP, S_BB, 32'h0, "wr1_masks_busy");
      push(D_BYP, S_RB, 32'h0000_0077, "wr1_bypass_b");
      push(D_NOB, S_BB, 32'h1, "wr1_unmasked_busy");
      push(D_NOB, S_RB, 32'h0000_0055, "wr1_no_bypass_b");
      cyc();
      idle();
      push(D_BOTH, S_BB, 32'h0, "busy_cleared");
      push(D_BOTH, S_BV, 32'h0, "busy_vec_cleared");
      push(D_BOTH, S_RB, 32'h0000_0077, "load_stored");

      // Simultaneous set and clear, then conflict
      cyc();
      sbs = 1'b1; sba = 5'd12;
      cyc();
      idle();
      push(D_BOTH, S_BV, 32'h0000_1000, "busy12_reset_up");
      cyc();
      sbs = 1'b1; sba = 5'd12;
      we1 = 1'b1; wa1 = 5'd12; wd1 = 32'h0000_0088;
      push(D_BOTH, S_CF, 32'h0, "conflict_before_setclr");
      cyc();
      idle();
      push(D_BOTH, S_BV, 32'h0000_1000, "set_wins_over_clear");
      push(D_BOTH, S_CF, 32'h0, "no_conflict_setclr");
      cyc();
      sbs = 1'b1; sba = 5'd12;
      push(D_BOTH, S_CF, 32'h0, "conflict_registered");
      cyc();
      idle();
      sbs = 1'b1; sba = 5'd0;
      push(D_BOTH, S_CF, 32'h1, "conflict_set");
      push(D_BOTH, S_BV, 32'h0000_1000, "busy12_still");
      cyc();
      idle();
      push(D_BOTH, S_CF, 32'h1, "conflict_sticky");
      push(D_BOTH, S_BV, 32'h0000_1000, "sb_addr0_ignored");

      // Asynchronous reset mid-operation
      cyc();
      we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h0000_0099;
      sbs = 1'b1; sba = 5'd3;
      cyc();
      idle();
      rd_a = 5'd3; rd_b = 5'd29;
      push(D_BOTH, S_RA, 32'h0000_0099, "reg3_written");
      push(D_BOTH, S_BV, 32'h0000_1008, "busy3_12");
      push(D_BOTH, S_CF, 32'h1, "conflict_before_reset");
      @(negedge clk);
      #2;
      reset = 1'b0;
      push(D_BOTH, S_BV, 32'h0, "async_reset_busy");
      push(D_BOTH, S_RA, 32'h0, "async_reset_reg3");
      push(D_BOTH, S_RB, 32'h0000_0400, "async_reset_sp");
      push(D_BOTH, S_CF, 32'h0, "async_reset_conflict");
      #1;
      -> check_now;
      cyc();
      push(D_BOTH, S_RA, 32'h0, "reg3_held_in_reset");
      cyc();
      reset = 1'b1;
      cyc();
      cyc();

      if (q.size() != 0) begin
         n_total++;
         $display("FAIL queue_drain: got %0d pending expected 0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
